traffic_sched: RTL

Phase scheduler for the crossroads signal head. It divides i_clk into a one-second tick and sequences the north-south (NS) and east-west (EW) light phases through green, yellow and all-red. It latches crossing requests and shortens the opposing green when a request is pending, and supports a flashing-yellow night mode. Its LED and BCD countdown outputs feed the existing LED pins and seven-segment decoders directly.

---
 rtl/traffic_pkg.sv | 43 ++++
 rtl/traffic_sched_tick_gen.sv | 29 ++
 rtl/traffic_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the crossroads phase scheduler.
// Also holds the BCD and lamp helpers used by traffic_sched.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_AR_A  = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_AR_B  = 3'd5,
        S_NIGHT = 3'd6
    } state_t;

    // Lamp vectors are {R,Y,G}.
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    // Returns {ns_lamps, ew_lamps} for a state; flash only matters in night mode.
    function automatic logic [5:0] lamp_pair(input state_t s, input logic flash);
        case (s)
            S_NS_G:  return {LAMP_G, LAMP_R};
            S_NS_Y:  return {LAMP_Y, LAMP_R};
            S_EW_G:  return {LAMP_R, LAMP_G};
            S_EW_Y:  return {LAMP_R, LAMP_Y};
            S_NIGHT: return flash ? {LAMP_Y, LAMP_Y} : {LAMP_OFF, LAMP_OFF};
            default: return {LAMP_R, LAMP_R};
        endcase
    endfunction

endpackage

// File: rtl/traffic_sched_tick_gen.sv
// Prescaler producing a registered one-cycle strobe every CLK_TICK+1 clocks.
module tick_gen #(
    parameter logic [31:0] CLK_TICK = 32'd50_000_000 - 32'd1
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    logic [31:0] r_presc;
    logic        r_tick;
    logic        w_wrap;

    assign w_wrap = (r_presc == CLK_TICK);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= w_wrap;
            r_presc <= w_wrap ? '0 : r_presc + 32'd1;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/traffic_sched.sv
// Crossroads phase scheduler: NS/EW green-yellow-all-red cycle with request
// truncation, flashing night mode and registered lamp/BCD countdown outputs.
module traffic_sched
    import traffic_pkg::*;
#(
    parameter logic [31:0] CLK_TICK = 32'd50_000_000 - 32'd1,
    parameter int          T_GREEN  = 25,
    parameter int          T_YELLOW = 5,
    parameter int          T_ALLRED = 2,
    parameter int          T_SHORT  = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_ns,
    input  logic       i_req_ew,
    input  logic       i_night,
    output logic [2:0] o_ledns,
    output logic [2:0] o_ledew,
    output logic [3:0] o_cnt_tens,
    output logic [3:0] o_cnt_ones,
    output logic [2:0] o_phase,
    output logic       o_tick
);

    localparam logic [6:0] C_GREEN  = 7'(T_GREEN);
    localparam logic [6:0] C_YELLOW = 7'(T_YELLOW);
    localparam logic [6:0] C_ALLRED = 7'(T_ALLRED);
    localparam logic [6:0] C_SHORT  = 7'(T_SHORT);

    state_t     r_state, w_state_nxt;
    logic [6:0] r_cnt, w_cnt_nxt;
    logic       r_flash, w_flash_nxt;
    logic       r_pend_ns, w_pend_ns_nxt;
    logic       r_pend_ew, w_pend_ew_nxt;
    logic [2:0] r_ledns, r_ledew;
    logic [3:0] r_tens, r_ones;
    logic [5:0] w_lamps_nxt;
    logic       w_tick;
    logic       w_trunc;

    tick_gen #(.CLK_TICK(CLK_TICK)) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    assign w_trunc = ((r_state == S_NS_G && r_pend_ew) || (r_state == S_EW_G && r_pend_ns))
                     && (r_cnt > C_SHORT);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_flash_nxt   = r_flash;
        w_pend_ns_nxt = r_pend_ns | i_req_ns;
        w_pend_ew_nxt = r_pend_ew | i_req_ew;

        // A truncation load takes priority over a coincident tick decrement.
        if (w_trunc) begin
            w_cnt_nxt = C_SHORT;
        end else if (w_tick) begin
            if (r_state == S_NIGHT) begin
                if (i_night) begin
                    w_flash_nxt = ~r_flash;
                end else begin
                    w_state_nxt = S_AR_B;
                    w_cnt_nxt   = C_ALLRED;
                    w_flash_nxt = 1'b0;
                end
            end else if (r_cnt != 7'd1) begin
                w_cnt_nxt = r_cnt - 7'd1;
            end else begin
                case (r_state)
                    S_NS_G: begin w_state_nxt = S_NS_Y; w_cnt_nxt = C_YELLOW; end
                    S_NS_Y: begin w_state_nxt = S_AR_A; w_cnt_nxt = C_ALLRED; end
                    S_AR_A: begin w_state_nxt = S_EW_G; w_cnt_nxt = C_GREEN;  end
                    S_EW_G: begin w_state_nxt = S_EW_Y; w_cnt_nxt = C_YELLOW; end
                    S_EW_Y: begin w_state_nxt = S_AR_B; w_cnt_nxt = C_ALLRED; end
                    default: begin w_state_nxt = S_NS_G; w_cnt_nxt = C_GREEN; end
                endcase
                // Night mode is only entered from an all-red phase.
                if ((r_state == S_AR_A || r_state == S_AR_B) && i_night) begin
                    w_state_nxt = S_NIGHT;
                    w_cnt_nxt   = 7'd0;
                    w_flash_nxt = 1'b1;
                end
            end
        end

        // Entry into a green serves its request, even one arriving this cycle.
        if (w_state_nxt == S_NS_G && r_state != S_NS_G) w_pend_ns_nxt = 1'b0;
        if (w_state_nxt == S_EW_G && r_state != S_EW_G) w_pend_ew_nxt = 1'b0;
    end

    assign w_lamps_nxt = lamp_pair(w_state_nxt, w_flash_nxt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_AR_B;
            r_cnt     <= C_ALLRED;
            r_flash   <= 1'b0;
            r_pend_ns <= 1'b0;
            r_pend_ew <= 1'b0;
            r_ledns   <= LAMP_R;
            r_ledew   <= LAMP_R;
            r_tens    <= bcd_tens(C_ALLRED);
            r_ones    <= bcd_ones(C_ALLRED);
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_flash   <= w_flash_nxt;
            r_pend_ns <= w_pend_ns_nxt;
            r_pend_ew <= w_pend_ew_nxt;
            r_ledns   <= w_lamps_nxt[5:3];
            r_ledew   <= w_lamps_nxt[2:0];
            r_tens    <= (w_state_nxt == S_NIGHT) ? BCD_BLANK : bcd_tens(w_cnt_nxt);
            r_ones    <= (w_state_nxt == S_NIGHT) ? BCD_BLANK : bcd_ones(w_cnt_nxt);
        end
    end

    assign o_ledns    = r_ledns;
    assign o_ledew    = r_ledew;
    assign o_cnt_tens = r_tens;
    assign o_cnt_ones = r_ones;
    assign o_phase    = r_state;
    assign o_tick     = w_tick;

endmodule
